// File: rtl/fast_pkg.sv
// rtl/fast_pkg.sv - shared constants and types for the FAST-16 corner pipeline
package fast_pkg;

    localparam int FAST_WIN    = 7;
    localparam int FAST_RADIUS = 3;
    localparam int FAST_NUM_LB = 6;
    localparam int FAST_PIX_W  = 8;

    // window[row][col]; row 0 is the newest line, col 6 the newest pixel
    typedef logic [FAST_PIX_W-1:0] fast_window_t [0:FAST_WIN-1][0:FAST_WIN-1];

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } fwg_state_t;

endpackage

// File: rtl/fast_line_buffer.sv
// rtl/fast_line_buffer.sv - one image line, async read, sync write, read-before-write
module fast_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 640
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/fast_window_generator.sv
// rtl/fast_window_generator.sv - raster stream to sliding 7x7 window for FAST-16
module fast_window_generator
    import fast_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pix_valid,
    input  logic                          pix_sof,
    input  logic [DATA_WIDTH-1:0]         pix_data,
    output logic                          window_valid,
    output logic [DATA_WIDTH-1:0]         window [0:FAST_WIN-1][0:FAST_WIN-1],
    output logic [$clog2(IMG_WIDTH)-1:0]  center_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] center_y,
    output logic                          frame_done,
    output logic                          overrun
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    fwg_state_t            state;
    logic [XW-1:0]         col_cnt;
    logic [YW-1:0]         row_cnt;
    logic [XW-1:0]         cur_c;
    logic [YW-1:0]         cur_r;
    logic                  accept;
    logic                  last_pix;
    logic                  in_image;
    logic [DATA_WIDTH-1:0] lb_rd   [FAST_NUM_LB];
    logic [DATA_WIDTH-1:0] lb_wr   [FAST_NUM_LB];
    logic [DATA_WIDTH-1:0] col_vec [FAST_WIN];

    // A start-of-frame pixel is always coordinate (0,0), even mid-frame
    always_comb begin
        accept   = pix_valid && (state == ST_ACTIVE || pix_sof);
        cur_c    = pix_sof ? '0 : col_cnt;
        cur_r    = pix_sof ? '0 : row_cnt;
        last_pix = (cur_c == XW'(IMG_WIDTH - 1)) && (cur_r == YW'(IMG_HEIGHT - 1));
        in_image = (cur_c >= XW'(FAST_WIN - 1)) && (cur_r >= YW'(FAST_WIN - 1));
        col_vec[0] = pix_data;
        for (int k = 0; k < FAST_NUM_LB; k++) begin
            col_vec[k+1] = lb_rd[k];
        end
    end

    // Cascade: each line buffer receives the line the previous one held
    generate
        for (genvar k = 0; k < FAST_NUM_LB; k++) begin : g_lb
            if (k == 0) begin : g_head
                assign lb_wr[k] = pix_data;
            end else begin : g_tail
                assign lb_wr[k] = lb_rd[k-1];
            end

            fast_line_buffer #(
                .DATA_WIDTH(DATA_WIDTH),
                .DEPTH     (IMG_WIDTH)
            ) u_lb (
                .clk  (clk),
                .we   (accept),
                .addr (cur_c),
                .wdata(lb_wr[k]),
                .rdata(lb_rd[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            col_cnt      <= '0;
            row_cnt      <= '0;
            window_valid <= 1'b0;
            center_x     <= '0;
            center_y     <= '0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < FAST_WIN; i++) begin
                for (int j = 0; j < FAST_WIN; j++) begin
                    window[i][j] <= '0;
                end
            end
        end else begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;

            if (pix_valid && !accept) begin
                overrun <= 1'b1;
            end

            if (accept) begin
                if (pix_sof) begin
                    overrun <= 1'b0;
                end

                for (int i = 0; i < FAST_WIN; i++) begin
                    for (int j = 0; j < FAST_WIN - 1; j++) begin
                        window[i][j] <= window[i][j+1];
                    end
                    window[i][FAST_WIN-1] <= col_vec[i];
                end

                // Windows straddling a line wrap hold mixed-line data and stay unflagged
                window_valid <= in_image;
                if (in_image) begin
                    center_x <= cur_c - XW'(FAST_RADIUS);
                    center_y <= cur_r - YW'(FAST_RADIUS);
                end

                if (last_pix) begin
                    state      <= ST_IDLE;
                    col_cnt    <= '0;
                    row_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    state <= ST_ACTIVE;
                    if (cur_c == XW'(IMG_WIDTH - 1)) begin
                        col_cnt <= '0;
                        row_cnt <= cur_r + YW'(1);
                    end else begin
                        col_cnt <= cur_c + XW'(1);
                        row_cnt <= cur_r;
                    end
                end
            end
        end
    end

endmodule

// File: doc/fast_window_generator.md
Name: fast_window_generator

Overview:
- Converts a raster pixel stream (one pixel per valid cycle, no backpressure) into a sliding 7x7 neighbourhood window for the FAST-16 corner pipeline.
- Holds six previous image lines in line buffers and a 7x7 register window.
- Asserts window_valid only when the whole window lies inside the image, and reports the image coordinate of the window centre.
- Drives the window_valid/window interface consumed by the FAST circle-sampling stage.

Parameters:
- DATA_WIDTH, 8, pixel bit width.
- IMG_WIDTH, 640, pixels per line; legal range 7 and above.
- IMG_HEIGHT, 480, lines per frame; legal range 7 and above.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- pix_valid  in  1  pixel present this cycle; always accepted.
- pix_sof  in  1  qualified by pix_valid; marks pixel (0,0) of a frame.
- pix_data  in  DATA_WIDTH  pixel value.
- window_valid  out  1  one-cycle pulse; window holds a fully in-image 7x7 neighbourhood.
- window  out  [0:6][0:6] x DATA_WIDTH  window[row][col].
- center_x  out  $clog2(IMG_WIDTH)  column of window[3][3].
- center_y  out  $clog2(IMG_HEIGHT)  row of window[3][3].
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- overrun  out  1  sticky; set when a pixel arrives while IDLE without pix_sof; cleared by an accepted pix_sof.

Behaviour:
- Reset values: window all 0, window_valid 0, center_x/center_y 0, frame_done 0, overrun 0, col_cnt/row_cnt 0, FSM in IDLE. Line buffer contents are not reset.
- FSM has two states, IDLE and ACTIVE.
  - IDLE, pix_valid with pix_sof: pixel is taken as (0,0), go to ACTIVE.
  - IDLE, pix_valid without pix_sof: pixel is dropped, overrun is set.
  - ACTIVE, pix_valid with pix_sof (mid-frame restart): counters reload to (0,0) and that pixel is processed as (0,0). No window_valid is produced until 6 rows and 6 columns of the new frame have been seen. Stale line-buffer data is never exposed.
  - ACTIVE, last pixel accepted (col_cnt=IMG_WIDTH-1, row_cnt=IMG_HEIGHT-1, no pix_sof): go to IDLE; frame_done pulses next cycle.
- Accepted pixel at (col c, row r):
  - Read lb[0..5][c] combinationally. Line buffers are register arrays with async read.
  - Form column vector v: v[0]=pix_data, v[k]=lb[k-1][c] for k=1..6.
  - Write lb[0][c]=pix_data and lb[k][c]=old lb[k-1][c] for k=1..5. Read-before-write within the same cycle.
  - Window shift: window[row][0..5] <= window[row][1..6] and window[row][6] <= v[row], for every row.
- Window convention:
  - Row 0 is the newest line (the current row), row 6 is the line 6 rows earlier.
  - Col 6 is the newest pixel, col 0 is 6 pixels earlier.
  - After pixel (c,r): window[i][j] = pixel(col c-6+j, row r-i).
- window_valid <= pix_valid & ACTIVE-accepted & (c>=6) & (r>=6), registered. Latency is 1 cycle from the pixel edge.
  - On the same edge: center_x <= c-3, center_y <= r-3.
- Cycles without pix_valid: window, center_x and center_y hold; window_valid is 0; counters hold.
- Counters:
  - col_cnt wraps IMG_WIDTH-1 -> 0 and increments row_cnt.
  - Windows that straddle a line wrap (c<6) are never flagged valid, even though the shift register holds mixed-line data.
- Valid windows per frame: (IMG_WIDTH-6)*(IMG_HEIGHT-6).
- Reset mid-frame: all outputs go to their reset values immediately and the FSM returns to IDLE; the next frame needs pix_sof.

Decomposition:
- Shared package fast_pkg: FAST_WIN=7, FAST_RADIUS=3, FAST_NUM_LB=6, and the window array typedef. The same typedef is used by the circle-sampling stage.
- One sub-module, fast_line_buffer: a single line of IMG_WIDTH x DATA_WIDTH, async read, sync write, read-before-write. Instantiated 6 times in a cascade.

Test Plan:
- Basic frame (IMG_WIDTH=16, IMG_HEIGHT=12, pixel=row*16+col, pix_valid every cycle).
  - First window_valid comes 1 cycle after pixel (6,6).
  - window[0][6]=102, window[6][0]=0, window[3][3]=51, center_x=3, center_y=3.
  - Exactly 60 valid pulses; frame_done once, 1 cycle after pixel 191.
- Gapped input: same frame with random pix_valid gaps (30% idle) -> identical window sequence and centre sequence; window_valid is never high on a cycle following an idle input cycle.
- Line boundary: pulse after pixel (15,7) has center_x=12, center_y=4; next pulse follows pixel (6,8) with center_x=3, center_y=5; no pulse for pixels (0..5,8).
- Pre-SOF junk: 5 pixels without pix_sof, then a normal frame -> the 5 pixels are dropped and overrun=1; overrun clears on pix_sof; window data matches the basic test.
- Mid-frame SOF: restart at pixel (4,9) with a fresh frame (values +100) -> no window_valid until the new pixel (6,6), which gives window[3][3]=151; no old-frame data appears in any valid window.
- Reset mid-frame: assert rst_n=0 at pixel (8,8) -> window_valid, frame_done, overrun and window become 0 immediately; the following frame with pix_sof reproduces the basic-test results.
